// File: rtl/triangle_scanner.sv
// Walks the screen-clipped bounding box of one triangle in raster order, issues point queries to
// in_triangle and buffers the inside pixels as fragments. Vertex layout: [26:18]=x, [17:9]=y, [8:0]=z.
module triangle_scanner #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        tri_valid_in,
   output logic        tri_ready_out,
   input  logic [26:0] v1_in,
   input  logic [26:0] v2_in,
   input  logic [26:0] v3_in,
   output logic [26:0] v1_out,
   output logic [26:0] v2_out,
   output logic [26:0] v3_out,
   output logic [8:0]  x_out,
   output logic [8:0]  y_out,
   output logic        valid_out,
   input  logic        in_tri_in,
   input  logic        in_tri_valid_in,
   output logic [8:0]  frag_x_out,
   output logic [8:0]  frag_y_out,
   output logic        frag_valid_out,
   input  logic        frag_ready_in,
   output logic        busy_out,
   output logic        done_out,
   output logic [2:0]  state_out
);

   // Handshakes: a triangle transfers when tri_valid_in & tri_ready_out at a rising edge; a fragment
   // pops when frag_valid_out & frag_ready_in; valid_out / in_tri_valid_in are one-cycle strobes.

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [8:0]  X_LAST = 9'(WIDTH - 1);
   localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);
   localparam logic [CW:0] CREDIT = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SCAN  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state;

   logic [8:0] cx, cy, xmin, xmax, ymax;
   logic [8:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;

   logic [17:0]   tag_mem [FIFO_DEPTH];
   logic [17:0]   frag_mem [FIFO_DEPTH];
   logic [PW-1:0] tag_wr, tag_rd, frag_wr, frag_rd;
   logic [CW-1:0] tag_count, frag_count;

   logic issue, tag_pop, frag_push, frag_pop, credit_ok;

   function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b,
                                       input logic [8:0] c);
      logic [8:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b,
                                       input logic [8:0] c);
      logic [8:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   always_comb begin
      bb_xmin = min3(v1_out[26:18], v2_out[26:18], v3_out[26:18]);
      bb_ymin = min3(v1_out[17:9], v2_out[17:9], v3_out[17:9]);
      bb_xmax = max3(v1_out[26:18], v2_out[26:18], v3_out[26:18]);
      bb_ymax = max3(v1_out[17:9], v2_out[17:9], v3_out[17:9]);
      if (bb_xmax > X_LAST) bb_xmax = X_LAST;
      if (bb_ymax > Y_LAST) bb_ymax = Y_LAST;
   end

   // Credit counts every outstanding query plus every buffered fragment, so a returning inside
   // result always has a fragment slot waiting for it.
   assign credit_ok = ({1'b0, tag_count} + {1'b0, frag_count}) < CREDIT;
   assign issue     = (state == S_SCAN) && credit_ok;
   assign tag_pop   = in_tri_valid_in && (tag_count != '0);
   assign frag_push = tag_pop && in_tri_in;
   assign frag_pop  = frag_valid_out && frag_ready_in;

   assign frag_valid_out = (frag_count != '0);
   assign frag_x_out     = frag_valid_out ? frag_mem[frag_rd][17:9] : 9'd0;
   assign frag_y_out     = frag_valid_out ? frag_mem[frag_rd][8:0] : 9'd0;
   assign state_out      = state;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state         <= S_IDLE;
         tri_ready_out <= 1'b1;
         busy_out      <= 1'b0;
         done_out      <= 1'b0;
         valid_out     <= 1'b0;
         x_out         <= 9'd0;
         y_out         <= 9'd0;
         v1_out        <= 27'd0;
         v2_out        <= 27'd0;
         v3_out        <= 27'd0;
         cx            <= 9'd0;
         cy            <= 9'd0;
         xmin          <= 9'd0;
         xmax          <= 9'd0;
         ymax          <= 9'd0;
      end else begin
         valid_out <= 1'b0;
         done_out  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tri_valid_in) begin
                  v1_out        <= v1_in;
                  v2_out        <= v2_in;
                  v3_out        <= v3_in;
                  tri_ready_out <= 1'b0;
                  busy_out      <= 1'b1;
                  state         <= S_SETUP;
               end
            end
            S_SETUP: begin
               if ((bb_xmin > X_LAST) || (bb_ymin > Y_LAST)) begin
                  done_out <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  xmin  <= bb_xmin;
                  xmax  <= bb_xmax;
                  ymax  <= bb_ymax;
                  cx    <= bb_xmin;
                  cy    <= bb_ymin;
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (issue) begin
                  valid_out <= 1'b1;
                  x_out     <= cx;
                  y_out     <= cy;
                  if (cx == xmax) begin
                     if (cy == ymax) begin
                        state <= S_DRAIN;
                     end else begin
                        cx <= xmin;
                        cy <= cy + 9'd1;
                     end
                  end else begin
                     cx <= cx + 9'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (tag_count == '0) begin
                  done_out <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               tri_ready_out <= 1'b1;
               busy_out      <= 1'b0;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tag_wr     <= '0;
         tag_rd     <= '0;
         tag_count  <= '0;
         frag_wr    <= '0;
         frag_rd    <= '0;
         frag_count <= '0;
      end else begin
         if (issue)     tag_wr  <= tag_wr + 1'b1;
         if (tag_pop)   tag_rd  <= tag_rd + 1'b1;
         if (frag_push) frag_wr <= frag_wr + 1'b1;
         if (frag_pop)  frag_rd <= frag_rd + 1'b1;
         tag_count  <= tag_count + CW'(issue) - CW'(tag_pop);
         frag_count <= frag_count + CW'(frag_push) - CW'(frag_pop);
      end
   end

   // Storage needs no reset: counts gate every read.
   always_ff @(posedge clk_in) begin
      if (issue)     tag_mem[tag_wr]   <= {cx, cy};
      if (frag_push) frag_mem[frag_wr] <= tag_mem[tag_rd];
   end

endmodule

// File: tb/tb_triangle_scanner.sv
// Bench for triangle_scanner: a 2-stage in_triangle model answers queries, a negedge monitor checks
// queries and fragments against queues filled from a raster/edge-function reference.
module tb_triangle_scanner;

   localparam int W = 320;
   localparam int H = 240;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tri_valid_in = 1'b0;
   logic        tri_ready_out;
   logic [26:0] v1_in = '0, v2_in = '0, v3_in = '0;
   logic [26:0] v1_out, v2_out, v3_out;
   logic [8:0]  x_out, y_out;
   logic        valid_out;
   logic        in_tri_in = 1'b0;
   logic        in_tri_valid_in = 1'b0;
   logic [8:0]  frag_x_out, frag_y_out;
   logic        frag_valid_out;
   logic        frag_ready_in = 1'b0;
   logic        busy_out, done_out;
   logic [2:0]  state_out;

   always #5 clk = ~clk;

   triangle_scanner #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clk_in(clk), .rst_n_in(rst_n),
      .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
      .v1_in(v1_in), .v2_in(v2_in), .v3_in(v3_in),
      .v1_out(v1_out), .v2_out(v2_out), .v3_out(v3_out),
      .x_out(x_out), .y_out(y_out), .valid_out(valid_out),
      .in_tri_in(in_tri_in), .in_tri_valid_in(in_tri_valid_in),
      .frag_x_out(frag_x_out), .frag_y_out(frag_y_out),
      .frag_valid_out(frag_valid_out), .frag_ready_in(frag_ready_in),
      .busy_out(busy_out), .done_out(done_out), .state_out(state_out)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int q_cnt = 0, f_cnt = 0, done_cnt = 0;
   int first_q_cyc = 0, last_q_cyc = 0;
   int plan_q = 0, plan_frags = 0;
   logic [98:0] exp_q[$];
   logic [17:0] frag_q[$];

   always @(posedge clk) cyc++;

   function automatic bit inside_tri(input logic [26:0] a, input logic [26:0] b,
                                     input logic [26:0] c, input logic [8:0] px9,
                                     input logic [8:0] py9);
      int ax, ay, bx, by, qx, qy, px, py, e0, e1, e2;
      ax = int'(a[26:18]); ay = int'(a[17:9]);
      bx = int'(b[26:18]); by = int'(b[17:9]);
      qx = int'(c[26:18]); qy = int'(c[17:9]);
      px = int'(px9); py = int'(py9);
      e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
      e1 = (qx - bx) * (py - by) - (qy - by) * (px - bx);
      e2 = (ax - qx) * (py - qy) - (ay - qy) * (px - qx);
      return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
   endfunction

   // in_triangle model: answers each query two negedges after sampling it.
   logic s1_v = 1'b0, s1_r = 1'b0, s2_v = 1'b0, s2_r = 1'b0;
   logic inject = 1'b0;
   always @(negedge clk) begin
      in_tri_valid_in = s2_v | inject;
      in_tri_in       = s2_r | inject;
      s2_v = s1_v;
      s2_r = s1_r;
      s1_v = valid_out;
      s1_r = valid_out && inside_tri(v1_out, v2_out, v3_out, x_out, y_out);
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      logic [98:0] e;
      logic [17:0] f;
      if (valid_out) begin
         q_cnt++;
         if (q_cnt == 1) first_q_cyc = cyc;
         last_q_cyc = cyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL query_unexpected got (%0d,%0d) expected none", x_out, y_out);
         end else begin
            e = exp_q.pop_front();
            if ({v1_out, v2_out, v3_out, x_out, y_out} !== e) begin
               bad++;
               $display("FAIL query got v=%h,%h,%h (%0d,%0d) expected v=%h,%h,%h (%0d,%0d)",
                        v1_out, v2_out, v3_out, x_out, y_out,
                        e[98:72], e[71:45], e[44:18], e[17:9], e[8:0]);
            end
         end
      end
      if (frag_valid_out && frag_ready_in) begin
         f_cnt++;
         total++;
         if (frag_q.size() == 0) begin
            bad++;
            $display("FAIL frag_unexpected got (%0d,%0d) expected none", frag_x_out, frag_y_out);
         end else begin
            f = frag_q.pop_front();
            if ({frag_x_out, frag_y_out} !== f) begin
               bad++;
               $display("FAIL frag got (%0d,%0d) expected (%0d,%0d)",
                        frag_x_out, frag_y_out, f[17:9], f[8:0]);
            end
         end
      end
      if (done_out) done_cnt++;
   end

   function automatic logic [26:0] vtx(input int x, input int y, input int z);
      return {9'(x), 9'(y), 9'(z)};
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic plan_tri(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c);
      int xs[3], ys[3];
      int xmin, xmax, ymin, ymax;
      xs[0] = int'(a[26:18]); xs[1] = int'(b[26:18]); xs[2] = int'(c[26:18]);
      ys[0] = int'(a[17:9]);  ys[1] = int'(b[17:9]);  ys[2] = int'(c[17:9]);
      xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
      for (int i = 1; i < 3; i++) begin
         if (xs[i] < xmin) xmin = xs[i];
         if (xs[i] > xmax) xmax = xs[i];
         if (ys[i] < ymin) ymin = ys[i];
         if (ys[i] > ymax) ymax = ys[i];
      end
      if (xmax > W - 1) xmax = W - 1;
      if (ymax > H - 1) ymax = H - 1;
      if (xmin > W - 1 || ymin > H - 1) return;
      for (int y = ymin; y <= ymax; y++) begin
         for (int x = xmin; x <= xmax; x++) begin
            exp_q.push_back({a, b, c, 9'(x), 9'(y)});
            plan_q++;
            if (inside_tri(a, b, c, 9'(x), 9'(y))) begin
               frag_q.push_back({9'(x), 9'(y)});
               plan_frags++;
            end
         end
      end
   endtask

   // Holds tri_valid_in until the DUT takes the triangle, then plans its expected output.
   task automatic wait_accept(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c);
      int k;
      v1_in = a; v2_in = b; v3_in = c;
      tri_valid_in = 1'b1;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (tri_ready_out) break;
      end
      if (k == 300) begin
         total++; bad++;
         $display("FAIL accept_timeout got ready=%0b expected 1", tri_ready_out);
      end
      @(posedge clk); #1;
      plan_tri(a, b, c);
   endtask

   task automatic send_tri(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c);
      wait_accept(a, b, c);
      tri_valid_in = 1'b0;
   endtask

   task automatic wait_done(input int start, input int budget);
      for (int k = 0; k < budget && done_cnt == start; k++) @(negedge clk);
      total++;
      if (done_cnt == start) begin
         bad++;
         $display("FAIL done_timeout got done_cnt=%0d expected >%0d", done_cnt, start);
      end
   endtask

   task automatic wait_frags(input int budget);
      for (int k = 0; k < budget && frag_q.size() != 0; k++) @(negedge clk);
      total++;
      if (frag_q.size() != 0) begin
         bad++;
         $display("FAIL frag_drain got pending=%0d expected 0", frag_q.size());
      end
      step(2);
      total++;
      if (frag_valid_out !== 1'b0) begin
         bad++;
         $display("FAIL frag_empty got valid=%0b expected 0", frag_valid_out);
      end
   endtask

   task automatic start_test();
      q_cnt = 0; f_cnt = 0; plan_q = 0; plan_frags = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(3);
      total++;
      if ({tri_ready_out, valid_out, frag_valid_out, busy_out, done_out} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_flags got %b expected 10000",
                  {tri_ready_out, valid_out, frag_valid_out, busy_out, done_out});
      end
      total++;
      if ({x_out, y_out, frag_x_out, frag_y_out, v1_out, v2_out, v3_out} !== '0) begin
         bad++;
         $display("FAIL reset_data got x=%0d y=%0d fx=%0d fy=%0d v1=%h expected all 0",
                  x_out, y_out, frag_x_out, frag_y_out, v1_out);
      end
      rst_n = 1'b1;
      step(2);
   endtask

   task automatic test_basic();
      int d0;
      start_test();
      frag_ready_in = 1'b1;
      d0 = done_cnt;
      send_tri(vtx(2, 4, 7), vtx(4, 1, 8), vtx(0, 0, 9));
      wait_done(d0, 200);
      step(4);
      total++;
      if (q_cnt != plan_q || q_cnt != 25) begin
         bad++;
         $display("FAIL basic_queries got %0d expected %0d", q_cnt, plan_q);
      end
      total++;
      if (last_q_cyc - first_q_cyc != 24) begin
         bad++;
         $display("FAIL basic_throughput got span=%0d expected 24", last_q_cyc - first_q_cyc);
      end
      total++;
      if (done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL basic_done got pulses=%0d expected 1", done_cnt - d0);
      end
      wait_frags(100);
      total++;
      if (f_cnt != plan_frags) begin
         bad++;
         $display("FAIL basic_frags got %0d expected %0d", f_cnt, plan_frags);
      end
   endtask

   task automatic test_backpressure();
      int d0, n, ins;
      logic [98:0] e;
      start_test();
      frag_ready_in = 1'b0;
      d0 = done_cnt;
      send_tri(vtx(2, 4, 0), vtx(4, 1, 0), vtx(0, 0, 0));
      n = 0; ins = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e = exp_q[i];
         n++;
         if (inside_tri(e[98:72], e[71:45], e[44:18], e[17:9], e[8:0])) ins++;
         if (ins == D) break;
      end
      step(80);
      total++;
      if (q_cnt != n) begin
         bad++;
         $display("FAIL stall_queries got %0d expected %0d", q_cnt, n);
      end
      total++;
      if ({frag_valid_out, busy_out, valid_out} !== 3'b110) begin
         bad++;
         $display("FAIL stall_flags got %b expected 110", {frag_valid_out, busy_out, valid_out});
      end
      frag_ready_in = 1'b1;
      wait_done(d0, 300);
      wait_frags(100);
      total++;
      if (q_cnt != plan_q || f_cnt != plan_frags) begin
         bad++;
         $display("FAIL stall_resume got q=%0d f=%0d expected q=%0d f=%0d",
                  q_cnt, f_cnt, plan_q, plan_frags);
      end
   endtask

   task automatic test_clip();
      int d0;
      start_test();
      frag_ready_in = 1'b1;
      d0 = done_cnt;
      send_tri(vtx(318, 238, 1), vtx(400, 250, 2), vtx(330, 300, 3));
      wait_done(d0, 100);
      wait_frags(50);
      total++;
      if (q_cnt != 4 || plan_q != 4) begin
         bad++;
         $display("FAIL clip_queries got %0d expected 4", q_cnt);
      end
      start_test();
      d0 = done_cnt;
      send_tri(vtx(320, 10, 0), vtx(400, 20, 0), vtx(330, 30, 0));
      wait_done(d0, 3);
      step(3);
      total++;
      if (q_cnt != 0 || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL offscreen got q=%0d done=%0d expected q=0 done=1", q_cnt, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      int d0, d_at_b;
      start_test();
      frag_ready_in = 1'b1;
      d0 = done_cnt;
      wait_accept(vtx(1, 1, 3), vtx(5, 2, 4), vtx(2, 6, 5));
      v1_in = vtx(10, 20, 6); v2_in = vtx(13, 20, 7); v3_in = vtx(10, 23, 8);
      @(negedge clk);
      total++;
      if ({tri_ready_out, busy_out} !== 2'b01) begin
         bad++;
         $display("FAIL b2b_not_ready got ready=%0b busy=%0b expected 0 1", tri_ready_out, busy_out);
      end
      wait_accept(vtx(10, 20, 6), vtx(13, 20, 7), vtx(10, 23, 8));
      d_at_b = done_cnt;
      tri_valid_in = 1'b0;
      total++;
      if (d_at_b - d0 != 1) begin
         bad++;
         $display("FAIL b2b_order got done_before_second=%0d expected 1", d_at_b - d0);
      end
      wait_done(d_at_b, 200);
      wait_frags(100);
      total++;
      if (q_cnt != plan_q || f_cnt != plan_frags) begin
         bad++;
         $display("FAIL b2b_counts got q=%0d f=%0d expected q=%0d f=%0d",
                  q_cnt, f_cnt, plan_q, plan_frags);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      bit seen;
      start_test();
      frag_ready_in = 1'b0;
      send_tri(vtx(2, 4, 0), vtx(4, 1, 0), vtx(0, 0, 0));
      for (k = 0; k < 100 && q_cnt < 6; k++) @(negedge clk);
      step(1);
      rst_n = 1'b0;
      #1;
      total++;
      if ({valid_out, frag_valid_out, tri_ready_out, busy_out} !== 4'b0010) begin
         bad++;
         $display("FAIL midreset got %b expected 0010",
                  {valid_out, frag_valid_out, tri_ready_out, busy_out});
      end
      exp_q.delete();
      frag_q.delete();
      step(2);
      rst_n = 1'b1;
      frag_ready_in = 1'b1;
      inject = 1'b1;
      step(1);
      inject = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (frag_valid_out) seen = 1'b1;
      end
      total++;
      if (seen || tri_ready_out !== 1'b1) begin
         bad++;
         $display("FAIL stale_result got frag_seen=%0b ready=%0b expected 0 1", seen, tri_ready_out);
      end
      step(1);
   endtask

   task automatic test_single();
      int d0;
      start_test();
      frag_ready_in = 1'b1;
      d0 = done_cnt;
      send_tri(vtx(5, 5, 1), vtx(5, 5, 1), vtx(5, 5, 1));
      wait_done(d0, 50);
      wait_frags(50);
      total++;
      if (q_cnt != 1 || f_cnt != 1 || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL single got q=%0d f=%0d done=%0d expected 1 1 1", q_cnt, f_cnt, done_cnt - d0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_clip();
      test_back_to_back();
      test_reset_mid();
      test_single();
      step(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
